// File: rtl/vfp_addsub_pipe_if.sv
// rtl/vfp_addsub_pipe_if.sv - operand/result bundle interface for the vector FP add/sub pipe
//
// Purpose : groups the input handshake (in_valid/in_ready), the operation
//           select and packed operands, and the output handshake
//           (out_valid/out_ready) with packed results and overflow flags.
// Ports   : in_valid, in_ready, sub, A, B        - operand side
//           out_valid, out_ready, Sum, Overflow  - result side
// Modports: master drives operands and out_ready; slave is the adder.
interface vfp_addsub_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int LANES = 4
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic               in_valid;
   logic               in_ready;
   logic               sub;
   logic [LANES*W-1:0] A;
   logic [LANES*W-1:0] B;
   logic               out_valid;
   logic               out_ready;
   logic [LANES*W-1:0] Sum;
   logic [LANES-1:0]   Overflow;

   modport master (
      output in_valid, sub, A, B, out_ready,
      input  in_ready, out_valid, Sum, Overflow
   );

   modport slave (
      input  in_valid, sub, A, B, out_ready,
      output in_ready, out_valid, Sum, Overflow
   );
endinterface

// File: rtl/vfp_addsub_pipe.sv
// rtl/vfp_addsub_pipe.sv - 3-stage multi-lane floating-point adder/subtractor
//
// Purpose : LANES independent {sign, exp, frac} adders, round to nearest even.
//           S1 classify/align, S2 add/subtract, S3 normalise/round/pack.
//           The whole pipe advances together; it freezes only when a result
//           is presented and not taken.
// Ports   : clk    - clock, all state on rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - slave side of vfp_addsub_pipe_if (operands, results,
//                    valid/ready handshakes, per-lane Overflow)
module vfp_addsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   vfp_addsub_pipe_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
   localparam int SW = $clog2(MW + 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   // position of the first set bit counted down from the hidden-bit slot
   function automatic logic [SW-1:0] lzc(input logic [MW-1:0] v);
      logic [SW-1:0] n;
      n = SW'(MW);
      for (int i = 0; i < MW; i++) begin
         if (v[i]) n = SW'(MW - 1 - i);
      end
      return n;
   endfunction

   logic adv;
   logic v1, v2, v3;

   // every stage moves in lock-step, so a single enable suffices
   assign adv          = !(v3 && !bus.out_ready);
   assign bus.in_ready = adv;
   assign bus.out_valid = v3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (adv) begin
         v1 <= bus.in_valid;
         v2 <= v1;
         v3 <= v2;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [W-1:0]       a, b;

      // S1 combinational
      logic               sa, sb;
      logic [EXP_W-1:0]   ea, eb, ea_eff, eb_eff, e_diff;
      logic [MAN_W:0]     ma, mb;
      logic               a_big;
      logic [MW-1:0]      m_sm_ext, m_sm_sh, lost_mask;
      logic [SW-1:0]      sh;
      logic               spc;
      logic [W-1:0]       spc_res;

      // S1 registers
      logic               s1_spc, s1_sign, s1_sub;
      logic [W-1:0]       s1_spc_res;
      logic [EXP_W-1:0]   s1_exp;
      logic [MW-1:0]      s1_mbig, s1_msm;

      // S2 combinational / registers
      logic [MW:0]        sum_c;
      logic               sign_c;
      logic               s2_spc, s2_sign;
      logic [W-1:0]       s2_spc_res;
      logic [EXP_W-1:0]   s2_exp;
      logic [MW:0]        s2_sum;

      // S3 combinational / output registers
      logic [SW-1:0]      lz;
      int                 lsh;
      logic [MW-1:0]      nm;
      logic [EXP_W:0]     ne, fe;
      logic               up, hid, ovf_c;
      logic [MAN_W+1:0]   rm;
      logic [MAN_W-1:0]   frac;
      logic [EXP_W-1:0]   enc;
      logic [W-1:0]       res_c;
      logic [W-1:0]       out_sum_q;
      logic               out_ovf_q;

      assign a = bus.A[g*W +: W];
      assign b = bus.B[g*W +: W];

      always_comb begin
         sa     = a[W-1];
         sb     = b[W-1] ^ bus.sub;
         ea     = a[MAN_W +: EXP_W];
         eb     = b[MAN_W +: EXP_W];
         ea_eff = (ea == '0) ? EXP_W'(1) : ea;
         eb_eff = (eb == '0) ? EXP_W'(1) : eb;
         ma     = {ea != '0, a[MAN_W-1:0]};
         mb     = {eb != '0, b[MAN_W-1:0]};
         // exponent-major compare is a magnitude compare once subnormals use exp 1
         a_big  = ({ea_eff, ma} >= {eb_eff, mb});
         e_diff = a_big ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
         sh     = (int'(e_diff) > MW) ? SW'(MW) : SW'(e_diff);
         m_sm_ext  = a_big ? {mb, 3'b000} : {ma, 3'b000};
         m_sm_sh   = m_sm_ext >> sh;
         lost_mask = ~({MW{1'b1}} << sh);
         spc     = 1'b0;
         spc_res = '0;
         if (ea == EXP_ONES) begin
            spc     = 1'b1;
            spc_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
         end else if (eb == EXP_ONES) begin
            spc     = 1'b1;
            spc_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_spc     <= 1'b0;
            s1_spc_res <= '0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_exp     <= '0;
            s1_mbig    <= '0;
            s1_msm     <= '0;
         end else if (adv) begin
            s1_spc     <= spc;
            s1_spc_res <= spc_res;
            s1_sign    <= a_big ? sa : sb;
            s1_sub     <= sa ^ sb;
            s1_exp     <= a_big ? ea_eff : eb_eff;
            s1_mbig    <= a_big ? {ma, 3'b000} : {mb, 3'b000};
            // everything that falls off the end folds into the sticky bit
            s1_msm     <= {m_sm_sh[MW-1:1],
                           m_sm_sh[0] | ((m_sm_ext & lost_mask) != '0)};
         end
      end

      always_comb begin
         sum_c  = s1_sub ? ({1'b0, s1_mbig} - {1'b0, s1_msm})
                         : ({1'b0, s1_mbig} + {1'b0, s1_msm});
         // exact cancellation always yields +0
         sign_c = (s1_sub && sum_c == '0) ? 1'b0 : s1_sign;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_spc     <= 1'b0;
            s2_spc_res <= '0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
         end else if (adv) begin
            s2_spc     <= s1_spc;
            s2_spc_res <= s1_spc_res;
            s2_sign    <= sign_c;
            s2_exp     <= s1_exp;
            s2_sum     <= sum_c;
         end
      end

      always_comb begin
         lz  = lzc(s2_sum[MW-1:0]);
         lsh = 0;
         if (s2_sum[MW]) begin
            nm = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
            ne = {1'b0, s2_exp} + 1'b1;
         end else begin
            // never normalise below exponent 1; what remains is subnormal
            lsh = (int'(lz) > int'(s2_exp) - 1) ? int'(s2_exp) - 1 : int'(lz);
            nm  = s2_sum[MW-1:0] << lsh;
            ne  = {1'b0, s2_exp} - (EXP_W+1)'(lsh);
         end
         up = nm[2] & (nm[1] | nm[0] | nm[3]);
         rm = {1'b0, nm[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
         if (rm[MAN_W+1]) begin
            fe   = ne + 1'b1;
            hid  = 1'b1;
            frac = rm[MAN_W:1];
         end else begin
            fe   = ne;
            hid  = rm[MAN_W];
            frac = rm[MAN_W-1:0];
         end
         enc   = hid ? fe[EXP_W-1:0] : {EXP_W{1'b0}};
         ovf_c = hid && (fe >= {1'b0, EXP_ONES});
         if (s2_spc) begin
            res_c = s2_spc_res;
            ovf_c = 1'b1;
         end else if (ovf_c) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         end else begin
            res_c = {s2_sign, enc, frac};
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
         end else if (adv) begin
            out_sum_q <= res_c;
            out_ovf_q <= ovf_c;
         end
      end

      assign bus.Sum[g*W +: W] = out_sum_q;
      assign bus.Overflow[g]   = out_ovf_q;
   end
endmodule

// File: doc/vfp_addsub_pipe.md
VFP_ADDSUB_PIPE -- requirements
Module: vfp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored fraction width.
REQ-003 SHALL have parameter LANES, default 4, number of independent adder lanes; W = 1+EXP_W+MAN_W per lane.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand bundle valid.
REQ-007 SHALL have port in_ready  output  1  unit accepts bundle this cycle.
REQ-008 SHALL have port sub  input  1  1 = A-B, 0 = A+B, applied to all lanes, captured with operands.
REQ-009 SHALL have port A  input  LANES*W  packed operands, lane i at bits [i*W +: W], format {sign, exp, frac}.
REQ-010 SHALL have port B  input  LANES*W  packed operands, same packing.
REQ-011 SHALL have port out_valid  output  1  result bundle valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port Sum  output  LANES*W  packed results, same packing.
REQ-014 SHALL have port Overflow  output  LANES  per-lane overflow/infinity flag.

Function
REQ-015 SHALL accept a bundle on a cycle where in_valid && in_ready; SHALL present a result on a cycle where out_valid && out_ready.
REQ-016 SHALL be a 3-stage pipeline: S1 classify/align, S2 add/subtract, S3 normalise/round/pack; latency exactly 3 cycles from accept to out_valid when never stalled.
REQ-017 SHALL sustain one bundle per cycle when out_ready is held 1.
REQ-018 SHALL set in_ready = !(out_valid && !out_ready); when low, all stages and their valid bits hold, and no input is captured.
REQ-019 SHALL keep Sum and Overflow stable while out_valid && !out_ready.
REQ-020 SHALL carry valid bits per stage, so bubbles propagate and are never presented as out_valid.
REQ-021 SHALL treat effective B sign as B.sign XOR sub.
REQ-022 SHALL treat exp == 0 as subnormal (no hidden 1, effective exponent 1), otherwise hidden 1.
REQ-023 SHALL align the smaller-exponent operand by right shift of the exponent difference, saturated at MAN_W+4, ORing all shifted-out bits into a sticky bit; guard and round bits kept.
REQ-024 SHALL add magnitudes when signs are equal, else subtract smaller from larger magnitude; result sign = sign of larger magnitude.
REQ-025 SHALL produce +0 (sign 0) when opposite-sign magnitudes are exactly equal.
REQ-026 SHALL normalise: right shift by 1 on carry-out; left shift by leading-zero count, stopping so the exponent never goes below 1, encoding exp 0 if hidden bit still 0 (subnormal result).
REQ-027 SHALL round to nearest, ties to even, using guard/round/sticky; a rounding carry SHALL renormalise and increment the exponent.
REQ-028 SHALL, when the final exponent reaches all-ones, output {sign, all-ones, 0} and Overflow = 1 for that lane.
REQ-029 SHALL, if A.exp is all-ones, output {A.sign, all-ones, 0} with Overflow = 1; else if B.exp is all-ones, output {effective B sign, all-ones, 0} with Overflow = 1; NaN payloads not preserved.
REQ-030 SHALL set Overflow = 0 for all other results.
REQ-031 SHALL compute lanes independently; a special case in one lane SHALL not affect others.

Reset
REQ-032 SHALL, while rst_n = 0, force all stage valid bits to 0, out_valid = 0, Sum = 0, Overflow = 0, independent of clk.
REQ-033 SHALL discard any in-flight bundles on reset mid-operation; first out_valid after release no earlier than 3 cycles after the first accept.
REQ-034 SHALL drive in_ready = 1 during and immediately after reset.

Verification (defaults, half precision, lane 0 shown; other lanes random, checked against a reference model)
REQ-035 SHALL verify A=3C00, B=3C00, sub=0 -> Sum=4000, Overflow=0, out_valid exactly 3 cycles after accept.
REQ-036 SHALL verify A=3C00, B=3800, sub=1 -> 3800; A=3C00, B=BC00, sub=0 -> 0000 (positive zero).
REQ-037 SHALL verify rounding: 3C00+1000 -> 3C00; 3C01+1000 -> 3C02; subnormal 0001+0001 -> 0002.
REQ-038 SHALL verify 7BFF+7BFF -> 7C00, Overflow=1; A=FC00, B=7C00 -> FC00, Overflow=1.
REQ-039 SHALL verify back-to-back streaming of 8 bundles with out_ready toggled 1/0 each cycle -> all 8 results in order, none dropped or duplicated, Sum stable while stalled.
REQ-040 SHALL verify rst_n pulsed low with 2 bundles in flight -> out_valid=0 and Sum=0 immediately; no stale result after release.
